text_ram_arbiter: RTL and testbench
===================================

TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

Interface
REQ-001 Parameter TEXT_BASE, default 11'd118: first writable text cell.
REQ-002 Parameter TEXT_LAST, default 11'd2047: last writable text cell (TEXT_LAST > TEXT_BASE).
REQ-003 Parameter BKSP_CODE, default 8'h66: keyboard scan code treated as backspace.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 data  in  8  keyboard scan code, qualified by valid.
REQ-007 valid  in  1  one-cycle keyboard event strobe.
REQ-008 released  in  1  with valid: 1 = key-release event, 0 = key-press.
REQ-009 h_req  in  1  host write request; held until h_ack.
REQ-010 h_addr  in  11  host target cell, held with h_req.
REQ-011 h_data  in  8  host write byte, held with h_req.
REQ-012 clr  in  1  one-cycle clear-screen request.
REQ-013 addr  out  11  text RAM write address (registered).
REQ-014 din  out  8  text RAM write data (registered).
REQ-015 wen  out  1  text RAM write enable (registered).
REQ-016 h_ack  out  1  one-cycle host grant, asserted in the cycle its write is on addr/din/wen.
REQ-017 cursor  out  11  current keyboard cursor cell, for display.
REQ-018 busy  out  1  clear sweep in progress.
REQ-019 kbd_ovf  out  1  one-cycle pulse: keyboard event dropped.

Function
REQ-020 Key-press events (valid=1, released=0) SHALL load a 1-deep pending slot: type BKSP if data==BKSP_CODE, else CHAR with data; release events SHALL be ignored.
REQ-021 Event arriving while slot full and not drained that cycle SHALL be dropped and pulse kbd_ovf; if slot drains the same cycle, the new event SHALL be captured.
REQ-022 FSM states IDLE and CLEAR; IDLE issues at most one write per cycle, output one cycle after grant decision.
REQ-023 In IDLE with both pending slot and h_req, grant SHALL alternate round-robin; pointer initialised to keyboard; a lone requester SHALL be granted immediately.
REQ-024 CHAR grant: addr=cursor, din=data, wen=1; cursor advances by 1, wrapping TEXT_LAST -> TEXT_BASE.
REQ-025 BKSP grant: if cursor>TEXT_BASE, cursor-=1 and write 8'hFF at new cursor; if cursor==TEXT_BASE, cursor holds and 8'hFF is written at TEXT_BASE.
REQ-026 Host grant: addr=h_addr, din=h_data, wen=1, h_ack=1; cursor unchanged; h_addr not range-checked.
REQ-027 No grant: wen=0, h_ack=0; addr/din hold.
REQ-028 Cursor SHALL never leave [TEXT_BASE, TEXT_LAST].

Reset
REQ-029 On rst_n=0 at clk edge: addr=0, din=0, wen=0, h_ack=0, busy=0, kbd_ovf=0, cursor=TEXT_BASE, slot empty, RR pointer=keyboard, state IDLE.
REQ-030 Reset mid-clear or mid-grant SHALL abort immediately; no further writes issued.

Configuration
REQ-031 Macro TEXT_CLEAR_EN defined: clr in IDLE enters CLEAR (priority over pending requests that cycle); sweep writes 8'hFF to TEXT_BASE..TEXT_LAST, one cell per cycle, busy=1 throughout; on final write, cursor=TEXT_BASE, return to IDLE.
REQ-032 In CLEAR: host stalled (no h_ack), keyboard slot held and still captures/overflows per REQ-021, clr ignored.
REQ-033 Macro TEXT_CLEAR_EN undefined: no CLEAR state, clr ignored, busy tied 0.

Verification
REQ-034 Reset, press data=8'h1C -> next cycle addr=118, din=8'h1C, wen=1; cursor=119; release event -> no write.
REQ-035 Cursor=2047, press 8'h1C -> write at 2047, cursor=118; at 118 press BKSP -> write 8'hFF at 118, cursor=118.
REQ-036 h_req held (h_addr=5, h_data=8'h41) with slot full every cycle -> grants alternate kbd, host, kbd; h_ack exactly once with addr=5, din=8'h41.
REQ-037 Slot full, host granted, two presses in consecutive cycles -> second drops, kbd_ovf one cycle; first still written later.
REQ-038 TEXT_CLEAR_EN: clr at cursor=300 -> busy=1 for 1930 cycles, 8'hFF written 118..2047 sequentially, then cursor=118; h_req during sweep acked only after.
REQ-039 rst_n=0 during clear at cell 500 -> wen=0 next cycle, busy=0, cursor=118.

Source files
------------

// File: rtl/text_ram_arbiter.sv
// rtl/text_ram_arbiter.sv - arbitrates keyboard and host writes into the text RAM
// Optional clear-screen sweep is built when TEXT_CLEAR_EN is defined.
module text_ram_arbiter #(
  parameter logic [10:0] TEXT_BASE = 11'd118,
  parameter logic [10:0] TEXT_LAST = 11'd2047,
  parameter logic [7:0]  BKSP_CODE = 8'h66
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        valid,
  input  logic        released,
  input  logic        h_req,
  input  logic [10:0] h_addr,
  input  logic [7:0]  h_data,
  input  logic        clr,
  output logic [10:0] addr,
  output logic [7:0]  din,
  output logic        wen,
  output logic        h_ack,
  output logic [10:0] cursor,
  output logic        busy,
  output logic        kbd_ovf
);

  logic       slot_full;
  logic       slot_bksp;
  logic [7:0] slot_data;
  logic       rr_host;
  logic       arb_en;
  logic       grant_kbd;
  logic       grant_host;
  logic       press;
  logic       host_req;
  logic       sweep;
  logic       sweep_last;
  logic [10:0] clr_ptr;

  assign press    = valid && !released;
  // The host still holds h_req during its ack cycle; it must not win twice.
  assign host_req = h_req && !h_ack;

`ifdef TEXT_CLEAR_EN
  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    arb_en     = 1'b0;
    sweep      = 1'b0;
    sweep_last = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr) state_nxt = S_CLEAR;
        else     arb_en    = 1'b1;
      end
      S_CLEAR: begin
        sweep = 1'b1;
        if (clr_ptr == TEXT_LAST) begin
          sweep_last = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     clr_ptr <= TEXT_BASE;
    else if (sweep) clr_ptr <= clr_ptr + 11'd1;
    else            clr_ptr <= TEXT_BASE;
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign arb_en     = 1'b1;
  assign sweep      = 1'b0;
  assign sweep_last = 1'b0;
  assign clr_ptr    = TEXT_BASE;
`endif

  always_comb begin
    grant_kbd  = 1'b0;
    grant_host = 1'b0;
    if (arb_en) begin
      if (slot_full && host_req) begin
        grant_host = rr_host;
        grant_kbd  = !rr_host;
      end else begin
        grant_kbd  = slot_full;
        grant_host = host_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= 11'd0;
      din       <= 8'd0;
      wen       <= 1'b0;
      h_ack     <= 1'b0;
      busy      <= 1'b0;
      kbd_ovf   <= 1'b0;
      cursor    <= TEXT_BASE;
      slot_full <= 1'b0;
      slot_bksp <= 1'b0;
      slot_data <= 8'd0;
      rr_host   <= 1'b0;
    end else begin
      wen     <= 1'b0;
      h_ack   <= 1'b0;
      kbd_ovf <= 1'b0;
      busy    <= sweep;

      // A press may refill the slot in the same cycle it is drained.
      if (press) begin
        if (!slot_full || grant_kbd) begin
          slot_full <= 1'b1;
          slot_bksp <= (data == BKSP_CODE);
          slot_data <= data;
        end else begin
          kbd_ovf <= 1'b1;
        end
      end else if (grant_kbd) begin
        slot_full <= 1'b0;
      end

      if (sweep) begin
        addr <= clr_ptr;
        din  <= 8'hFF;
        wen  <= 1'b1;
        if (sweep_last) cursor <= TEXT_BASE;
      end else if (grant_host) begin
        addr    <= h_addr;
        din     <= h_data;
        wen     <= 1'b1;
        h_ack   <= 1'b1;
        rr_host <= 1'b0;
      end else if (grant_kbd) begin
        wen     <= 1'b1;
        rr_host <= 1'b1;
        if (slot_bksp) begin
          din <= 8'hFF;
          if (cursor > TEXT_BASE) begin
            cursor <= cursor - 11'd1;
            addr   <= cursor - 11'd1;
          end else begin
            addr <= TEXT_BASE;
          end
        end else begin
          addr   <= cursor;
          din    <= slot_data;
          cursor <= (cursor >= TEXT_LAST) ? TEXT_BASE : cursor + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// tb/tb_text_ram_arbiter.sv - directed self-checking bench for text_ram_arbiter
// Clear-sweep scenarios run when TEXT_CLEAR_EN is defined.
module tb_text_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        released;
  logic        h_req;
  logic [10:0] h_addr;
  logic [7:0]  h_data;
  logic        clr;
  logic [10:0] addr;
  logic [7:0]  din;
  logic        wen;
  logic        h_ack;
  logic [10:0] cursor;
  logic        busy;
  logic        kbd_ovf;

  int assertions = 0;
  int failures   = 0;

  text_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .released(released),
    .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .clr(clr),
    .addr(addr), .din(din), .wen(wen), .h_ack(h_ack), .cursor(cursor),
    .busy(busy), .kbd_ovf(kbd_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; released = 1'b0; data = 8'd0;
    h_req = 1'b0; h_addr = 11'd0; h_data = 8'd0; clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic press_key(input logic [7:0] code);
    valid = 1'b1; released = 1'b0; data = code;
    tick();
    valid = 1'b0;
  endtask

  // n consecutive presses, one per cycle, then let the last one drain.
  task automatic type_chars(input int n, output int ovf_seen);
    ovf_seen = 0;
    for (int i = 0; i < n; i++) begin
      valid = 1'b1; released = 1'b0; data = 8'h20;
      tick();
      if (kbd_ovf) ovf_seen++;
    end
    valid = 1'b0;
    tick();
    if (kbd_ovf) ovf_seen++;
  endtask

  task automatic test_reset();
    do_reset();
    assertions++; if (addr !== 11'd0)   begin failures++; $display("FAIL reset_addr got %0d exp 0", addr); end
    assertions++; if (din !== 8'd0)     begin failures++; $display("FAIL reset_din got %0h exp 0", din); end
    assertions++; if (wen !== 1'b0)     begin failures++; $display("FAIL reset_wen got %0b exp 0", wen); end
    assertions++; if (h_ack !== 1'b0)   begin failures++; $display("FAIL reset_hack got %0b exp 0", h_ack); end
    assertions++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got %0b exp 0", busy); end
    assertions++; if (kbd_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %0b exp 0", kbd_ovf); end
    assertions++; if (cursor !== 11'd118) begin failures++; $display("FAIL reset_cursor got %0d exp 118", cursor); end
  endtask

  task automatic test_char_and_release();
    do_reset();
    press_key(8'h1C);
    assertions++; if (wen !== 1'b0) begin failures++; $display("FAIL char_latency got wen=%0b exp 0", wen); end
    tick();
    assertions++; if (wen !== 1'b1 || addr !== 11'd118 || din !== 8'h1C)
      begin failures++; $display("FAIL char_write got wen=%0b addr=%0d din=%0h exp 1/118/1c", wen, addr, din); end
    assertions++; if (cursor !== 11'd119) begin failures++; $display("FAIL char_cursor got %0d exp 119", cursor); end
    valid = 1'b1; released = 1'b1; data = 8'h1C;
    tick();
    valid = 1'b0; released = 1'b0;
    assertions++; if (wen !== 1'b0) begin failures++; $display("FAIL release_a got wen=%0b exp 0", wen); end
    tick();
    assertions++; if (wen !== 1'b0 || cursor !== 11'd119)
      begin failures++; $display("FAIL release_b got wen=%0b cursor=%0d exp 0/119", wen, cursor); end
  endtask

  task automatic test_backspace();
    press_key(8'h66);
    tick();
    assertions++; if (wen !== 1'b1 || addr !== 11'd118 || din !== 8'hFF || cursor !== 11'd118)
      begin failures++; $display("FAIL bksp_mid got wen=%0b addr=%0d din=%0h cur=%0d exp 1/118/ff/118", wen, addr, din, cursor); end
  endtask

  task automatic test_wrap();
    int ovf;
    do_reset();
    type_chars(1929, ovf);
    assertions++; if (ovf !== 0) begin failures++; $display("FAIL wrap_no_ovf got %0d exp 0", ovf); end
    assertions++; if (cursor !== 11'd2047) begin failures++; $display("FAIL wrap_pre_cursor got %0d exp 2047", cursor); end
    press_key(8'h1C);
    tick();
    assertions++; if (wen !== 1'b1 || addr !== 11'd2047 || din !== 8'h1C)
      begin failures++; $display("FAIL wrap_write got wen=%0b addr=%0d din=%0h exp 1/2047/1c", wen, addr, din); end
    assertions++; if (cursor !== 11'd118) begin failures++; $display("FAIL wrap_cursor got %0d exp 118", cursor); end
    press_key(8'h66);
    tick();
    assertions++; if (wen !== 1'b1 || addr !== 11'd118 || din !== 8'hFF || cursor !== 11'd118)
      begin failures++; $display("FAIL bksp_base got wen=%0b addr=%0d din=%0h cur=%0d exp 1/118/ff/118", wen, addr, din, cursor); end
  endtask

  task automatic test_round_robin();
    int acks;
    do_reset();
    press_key(8'h31);
    h_req = 1'b1; h_addr = 11'd5; h_data = 8'h41;
    valid = 1'b1; data = 8'h32;
    tick();
    valid = 1'b0;
    acks = h_ack ? 1 : 0;
    assertions++; if (wen !== 1'b1 || addr !== 11'd118 || din !== 8'h31 || h_ack !== 1'b0)
      begin failures++; $display("FAIL rr_kbd1 got wen=%0b addr=%0d din=%0h ack=%0b exp 1/118/31/0", wen, addr, din, h_ack); end
    tick();
    if (h_ack) begin acks++; h_req = 1'b0; end
    assertions++; if (wen !== 1'b1 || addr !== 11'd5 || din !== 8'h41 || h_ack !== 1'b1)
      begin failures++; $display("FAIL rr_host got wen=%0b addr=%0d din=%0h ack=%0b exp 1/5/41/1", wen, addr, din, h_ack); end
    tick();
    if (h_ack) acks++;
    h_req = 1'b0;
    assertions++; if (wen !== 1'b1 || addr !== 11'd119 || din !== 8'h32)
      begin failures++; $display("FAIL rr_kbd2 got wen=%0b addr=%0d din=%0h exp 1/119/32", wen, addr, din); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (h_ack) acks++;
    end
    assertions++; if (acks !== 1) begin failures++; $display("FAIL rr_ack_count got %0d exp 1", acks); end
  endtask

  task automatic test_overflow();
    do_reset();
    press_key(8'h51);
    h_req = 1'b1; h_addr = 11'd9; h_data = 8'h42;
    valid = 1'b1; data = 8'h52;
    tick();
    data = 8'h53;
    assertions++; if (addr !== 11'd118 || din !== 8'h51 || kbd_ovf !== 1'b0)
      begin failures++; $display("FAIL ovf_first got addr=%0d din=%0h ovf=%0b exp 118/51/0", addr, din, kbd_ovf); end
    tick();
    valid = 1'b0; h_req = 1'b0;
    assertions++; if (h_ack !== 1'b1 || addr !== 11'd9 || kbd_ovf !== 1'b1)
      begin failures++; $display("FAIL ovf_pulse got ack=%0b addr=%0d ovf=%0b exp 1/9/1", h_ack, addr, kbd_ovf); end
    tick();
    assertions++; if (kbd_ovf !== 1'b0 || wen !== 1'b1 || addr !== 11'd119 || din !== 8'h52)
      begin failures++; $display("FAIL ovf_drain got ovf=%0b wen=%0b addr=%0d din=%0h exp 0/1/119/52", kbd_ovf, wen, addr, din); end
    tick();
    assertions++; if (wen !== 1'b0 || cursor !== 11'd120)
      begin failures++; $display("FAIL ovf_dropped got wen=%0b cursor=%0d exp 0/120", wen, cursor); end
  endtask

`ifdef TEXT_CLEAR_EN
  task automatic test_clear();
    int ovf, n, bad, ackd_in_busy;
    logic [10:0] exp_addr;
    do_reset();
    type_chars(182, ovf);
    assertions++; if (cursor !== 11'd300) begin failures++; $display("FAIL clr_pre_cursor got %0d exp 300", cursor); end
    clr = 1'b1; h_req = 1'b1; h_addr = 11'd7; h_data = 8'h55;
    tick();
    clr = 1'b0;
    assertions++; if (h_ack !== 1'b0) begin failures++; $display("FAIL clr_priority got ack=%0b exp 0", h_ack); end
    n = 0; bad = 0; ackd_in_busy = 0; exp_addr = 11'd118;
    for (int i = 0; i < 2100; i++) begin
      tick();
      if (busy) begin
        if (wen !== 1'b1 || din !== 8'hFF || addr !== exp_addr) bad++;
        if (h_ack) ackd_in_busy++;
        exp_addr = exp_addr + 11'd1;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    assertions++; if (n !== 1930) begin failures++; $display("FAIL clr_busy_cycles got %0d exp 1930", n); end
    assertions++; if (bad !== 0) begin failures++; $display("FAIL clr_sweep_writes got %0d bad exp 0", bad); end
    assertions++; if (ackd_in_busy !== 0) begin failures++; $display("FAIL clr_host_stall got %0d acks exp 0", ackd_in_busy); end
    assertions++; if (cursor !== 11'd118) begin failures++; $display("FAIL clr_cursor got %0d exp 118", cursor); end
    assertions++; if (h_ack !== 1'b1 || addr !== 11'd7 || din !== 8'h55)
      begin failures++; $display("FAIL clr_host_after got ack=%0b addr=%0d din=%0h exp 1/7/55", h_ack, addr, din); end
    h_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int found, stray;
    do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    found = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (wen && addr == 11'd500) begin found = 1; break; end
    end
    assertions++; if (found !== 1) begin failures++; $display("FAIL rstclr_reach500 got %0d exp 1", found); end
    rst_n = 1'b0;
    tick();
    assertions++; if (wen !== 1'b0 || busy !== 1'b0 || cursor !== 11'd118)
      begin failures++; $display("FAIL rstclr_abort got wen=%0b busy=%0b cur=%0d exp 0/0/118", wen, busy, cursor); end
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wen || busy) stray++;
    end
    assertions++; if (stray !== 0) begin failures++; $display("FAIL rstclr_no_resume got %0d exp 0", stray); end
  endtask
`else
  task automatic test_clr_ignored();
    do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    assertions++; if (busy !== 1'b0 || wen !== 1'b0)
      begin failures++; $display("FAIL clr_ignored got busy=%0b wen=%0b exp 0/0", busy, wen); end
    press_key(8'h1C);
    tick();
    assertions++; if (wen !== 1'b1 || addr !== 11'd118 || busy !== 1'b0)
      begin failures++; $display("FAIL clr_ignored_kbd got wen=%0b addr=%0d busy=%0b exp 1/118/0", wen, addr, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_char_and_release();
    test_backspace();
    test_wrap();
    test_round_robin();
    test_overflow();
`ifdef TEXT_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clr_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
